// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - ALU execute stage: single-cycle logic/arith, 32-cycle iterative MUL/DIV
// Holds result and flags in DONE until the writeback consumer takes them.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       sel,
  input  logic [WIDTH-1:0] data_I,
  input  logic [WIDTH-1:0] data_II,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_ovf,
  output logic             flag_dz,
  output logic             flag_ill
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_result, r_result_hi;
  logic               r_zero, r_carry, r_ovf, r_dz, r_ill;

  logic               w_accept, w_is_mul, w_is_div, w_last;
  logic [WIDTH:0]     w_add;
  logic [WIDTH-1:0]   w_sub;
  logic [WIDTH-1:0]   w_res, w_res_hi;
  logic               w_zero, w_carry, w_ovf, w_dz, w_ill;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_prod_nx;
  logic [WIDTH:0]     w_rem_sh, w_diff;
  logic [WIDTH-1:0]   w_rem_nx, w_quo_nx;

  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = (r_state == S_DONE);
  assign result     = r_result;
  assign result_hi  = r_result_hi;
  assign flag_zero  = r_zero;
  assign flag_carry = r_carry;
  assign flag_ovf   = r_ovf;
  assign flag_dz    = r_dz;
  assign flag_ill   = r_ill;

  assign w_accept = in_valid && (r_state == S_IDLE);
  assign w_is_mul = (sel == 4'b0010);
  assign w_is_div = (sel == 4'b0011) && (data_II != '0);
  assign w_last   = (r_cnt == CNT_W'(WIDTH-1));

  // Shift-add multiply: conditionally add multiplicand into the high half, then shift right
  assign w_mul_sum = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_opnd} : '0);
  assign w_prod_nx = {w_mul_sum, r_prod[WIDTH-1:1]};

  // Restoring divide: dividend bits shift out of r_quo while quotient bits shift in
  assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_opnd};
  assign w_rem_nx = w_diff[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign w_quo_nx = {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};

  assign w_add = {1'b0, data_I} + {1'b0, data_II};
  assign w_sub = data_I - data_II;

  always_comb begin
    w_res    = '0;
    w_res_hi = '0;
    w_carry  = 1'b0;
    w_ovf    = 1'b0;
    w_dz     = 1'b0;
    w_ill    = 1'b0;
    case (sel)
      4'b0000: begin
        w_res   = w_sub;
        w_carry = (data_I < data_II);
        w_ovf   = (data_I[WIDTH-1] != data_II[WIDTH-1]) && (w_sub[WIDTH-1] != data_I[WIDTH-1]);
      end
      4'b0001: begin
        w_res   = w_add[WIDTH-1:0];
        w_carry = w_add[WIDTH];
        w_ovf   = (data_I[WIDTH-1] == data_II[WIDTH-1]) && (w_add[WIDTH-1] != data_I[WIDTH-1]);
      end
      4'b0011: begin
        w_res    = '1;
        w_res_hi = data_I;
        w_dz     = 1'b1;
      end
      4'b0100: w_ill = 1'b1;
      4'b0101: w_res = data_I & data_II;
      4'b0110: w_res = data_I | data_II;
      4'b0111: w_res = ~(data_I & data_II);
      4'b1000: w_res = ~(data_I | data_II);
      4'b1001: w_res = data_I ^ data_II;
      4'b1010: w_res = ~(data_I ^ data_II);
      4'b1011: w_res = ~data_I;
      4'b1100: w_res = {{(WIDTH-1){1'b0}}, (|data_I) && (|data_II)};
      4'b1101: w_res = {{(WIDTH-1){1'b0}}, (|data_I) || (|data_II)};
      4'b1110: w_res = data_I << data_II[CNT_W-1:0];
      4'b1111: w_res = data_I >> data_II[CNT_W-1:0];
      default: w_res = '0;
    endcase
    w_zero = (w_res == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_is_mul ? S_MUL : (w_is_div ? S_DIV : S_DONE);
      S_MUL:  if (w_last) w_next = S_DONE;
      S_DIV:  if (w_last) w_next = S_DONE;
      S_DONE: if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_prod      <= '0;
      r_opnd      <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_zero      <= 1'b0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
      r_dz        <= 1'b0;
      r_ill       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_cnt <= '0;
          if (w_is_mul) begin
            r_prod <= {{WIDTH{1'b0}}, data_II};
            r_opnd <= data_I;
          end else if (w_is_div) begin
            r_rem  <= '0;
            r_quo  <= data_I;
            r_opnd <= data_II;
          end else begin
            r_result    <= w_res;
            r_result_hi <= w_res_hi;
            r_zero      <= w_zero;
            r_carry     <= w_carry;
            r_ovf       <= w_ovf;
            r_dz        <= w_dz;
            r_ill       <= w_ill;
          end
        end
        S_MUL: begin
          r_prod <= w_prod_nx;
          r_cnt  <= r_cnt + 1'b1;
          if (w_last) begin
            r_result    <= w_prod_nx[WIDTH-1:0];
            r_result_hi <= w_prod_nx[2*WIDTH-1:WIDTH];
            r_zero      <= (w_prod_nx == '0);
            {r_carry, r_ovf, r_dz, r_ill} <= 4'b0;
          end
        end
        S_DIV: begin
          r_rem <= w_rem_nx;
          r_quo <= w_quo_nx;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_result    <= w_quo_nx;
            r_result_hi <= w_rem_nx;
            r_zero      <= (w_quo_nx == '0);
            {r_carry, r_ovf, r_dz, r_ill} <= 4'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - randomized and directed bench for alu_exec_unit against an arithmetic model
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  sel;
  logic [31:0] data_I, data_II, result, result_hi;
  logic        flag_zero, flag_carry, flag_ovf, flag_dz, flag_ill;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] res;
    logic [31:0] hi;
    logic [4:0]  flags;
    int          lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  bit   seen = 0;

  alu_exec_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .data_I(data_I), .data_II(data_II),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi),
    .flag_zero(flag_zero), .flag_carry(flag_carry), .flag_ovf(flag_ovf),
    .flag_dz(flag_dz), .flag_ill(flag_ill)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, want, $time);
    end
  endtask

  // Flags packed as {zero, carry, ovf, dz, ill}
  function automatic exp_t model(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint unsigned u;
    longint sg;
    logic [4:0] sh;
    bit z, c, o, dz, il;
    e.res = 0; e.hi = 0; e.lat = 1; e.acc = 0;
    c = 0; o = 0; dz = 0; il = 0;
    sh = b[4:0];
    case (s)
      4'd0: begin
        e.res = a - b;
        c = (a < b);
        sg = longint'($signed(a)) - longint'($signed(b));
        o = (sg > 64'sd2147483647) || (sg < -64'sd2147483648);
      end
      4'd1: begin
        u = longint'(a) + longint'(b);
        e.res = u[31:0];
        c = u[32];
        sg = longint'($signed(a)) + longint'($signed(b));
        o = (sg > 64'sd2147483647) || (sg < -64'sd2147483648);
      end
      4'd2: begin
        u = longint'(a) * longint'(b);
        e.res = u[31:0];
        e.hi = u[63:32];
        e.lat = 33;
      end
      4'd3: begin
        if (b == 0) begin
          e.res = 32'hFFFF_FFFF; e.hi = a; dz = 1;
        end else begin
          e.res = a / b; e.hi = a % b; e.lat = 33;
        end
      end
      4'd4:  il = 1;
      4'd5:  e.res = a & b;
      4'd6:  e.res = a | b;
      4'd7:  e.res = ~(a & b);
      4'd8:  e.res = ~(a | b);
      4'd9:  e.res = a ^ b;
      4'd10: e.res = ~(a ^ b);
      4'd11: e.res = ~a;
      4'd12: e.res = (a != 0 && b != 0) ? 1 : 0;
      4'd13: e.res = (a != 0 || b != 0) ? 1 : 0;
      4'd14: e.res = a << sh;
      default: e.res = a >> sh;
    endcase
    z = (s == 4'd2) ? ({e.hi, e.res} == 64'd0) : (e.res == 0);
    e.flags = {z, c, o, dz, il};
    return e;
  endfunction

  // Checks every cycle: reset values, in_ready vs outstanding work, latency and held outputs
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
      seen = 0;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result", {result_hi, result}, 0);
      chk("rst_flags", {flag_zero, flag_carry, flag_ovf, flag_dz, flag_ill}, 0);
    end else begin
      chk("in_ready", in_ready, exp_q.size() == 0);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("out_valid_unexpected", out_valid, 0);
        end else begin
          e = exp_q[0];
          if (!seen) chk("latency", cyc - e.acc, e.lat);
          seen = 1;
          chk("result", result, e.res);
          chk("result_hi", result_hi, e.hi);
          chk("flags", {flag_zero, flag_carry, flag_ovf, flag_dz, flag_ill}, e.flags);
          if (out_ready) begin
            void'(exp_q.pop_front());
            seen = 0;
          end
        end
      end
      if (in_valid && in_ready) begin
        e = model(sel, data_I, data_II);
        e.acc = cyc;
        exp_q.push_back(e);
      end
    end
    cyc++;
  end

  task automatic run_op(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b,
                        input int stall, input bit junk, output int lat);
    int n;
    @(posedge clk); #1;
    sel = s; data_I = a; data_II = b; in_valid = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ready && n < 200);
    @(posedge clk); #1;
    in_valid = 0; sel = 4'($urandom); data_I = $urandom; data_II = $urandom;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!out_valid && lat < 200);
    chk("done_timeout", out_valid, 1);
    #1;
    if (junk) begin
      in_valid = 1; sel = 4'd1; data_I = 32'd3; data_II = 32'd4;
    end
    repeat (stall) @(negedge clk);
    @(posedge clk); #1 out_ready = 1; in_valid = 0;
    @(posedge clk); #1 out_ready = 0;
  endtask

  task automatic chk_out(input string nm, input logic [31:0] r, input logic [31:0] h, input logic [4:0] f);
    chk({nm, "_res"}, result, r);
    chk({nm, "_hi"}, result_hi, h);
    chk({nm, "_flags"}, {flag_zero, flag_carry, flag_ovf, flag_dz, flag_ill}, f);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'($urandom_range(1, 40));
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat, n;
    rst_n = 0; in_valid = 0; out_ready = 0; sel = 0; data_I = 0; data_II = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    run_op(4'd1, 32'hFFFF_FFFF, 32'h1, 0, 0, lat);
    chk("add_lat", lat, 1);
    chk_out("add", 32'h0, 32'h0, 5'b11000);

    run_op(4'd0, 32'h8000_0000, 32'h1, 1, 0, lat);
    chk_out("sub_ovf", 32'h7FFF_FFFF, 32'h0, 5'b00100);
    run_op(4'd0, 32'h1, 32'h2, 0, 0, lat);
    chk_out("sub_borrow", 32'hFFFF_FFFF, 32'h0, 5'b01000);

    run_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, lat);
    chk("mul_lat", lat, 33);
    chk_out("mul", 32'h1, 32'hFFFF_FFFE, 5'b00000);

    run_op(4'd3, 32'd100, 32'd7, 0, 0, lat);
    chk("div_lat", lat, 33);
    chk_out("div", 32'd14, 32'd2, 5'b00000);
    run_op(4'd3, 32'd5, 32'd0, 0, 0, lat);
    chk("divz_lat", lat, 1);
    chk_out("divz", 32'hFFFF_FFFF, 32'd5, 5'b00010);

    run_op(4'd9, 32'hF0F0_F0F0, 32'hFFFF_0000, 10, 1, lat);
    chk_out("xor_hold", 32'h0F0F_F0F0, 32'h0, 5'b00000);

    // Reset in the middle of a multiply must abort with no result presented
    @(posedge clk); #1;
    sel = 4'd2; data_I = 32'h1234_5678; data_II = 32'h9ABC_DEF0; in_valid = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ready && n < 200);
    @(posedge clk); #1 in_valid = 0;
    repeat (14) @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk_out("abort", 32'h0, 32'h0, 5'b00000);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1;

    run_op(4'd4, 32'hDEAD_BEEF, 32'h1, 0, 0, lat);
    chk_out("illegal", 32'h0, 32'h0, 5'b10001);

    for (int i = 0; i < 250; i++) begin
      run_op(4'($urandom), pick_operand(), pick_operand(), $urandom_range(0, 3), 0, lat);
    end

    repeat (3) @(posedge clk);
    chk("drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
